nucl_sample_packer: RTL

Return path of the PE substitution stage. PE expands a packed parent alignment word into per-nucleotide P-matrix rows. This block does the reverse: it consumes one selected 40-bit row per nucleotide plus a uniform random value, samples the child nucleotide, and packs the results back into 32-bit nucl_alig-format words for the alignment writer. Valid/ready handshakes on both sides; supports partial-word flush.

---
 rtl/nucl_sample_packer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/nucl_sample_packer.sv
// Samples one child nucleotide per cumulative-probability row and packs the
// 2-bit codes into nucl_alig words. Optional row-monotonicity flag: PROB_ROW_CHECK_EN.
module nucl_sample_packer #(
  parameter int PROB_W        = 10,
  parameter int NUCL_PER_WORD = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       row_valid,
  output logic                       row_ready,
  input  logic [4*PROB_W-1:0]        row_data,
  input  logic [PROB_W-1:0]          rand_val,
  input  logic                       row_last,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [2*NUCL_PER_WORD-1:0] word_data,
  output logic [4:0]                 word_len,
  output logic                       prob_err
);

  localparam int IDX_W  = (NUCL_PER_WORD > 1) ? $clog2(NUCL_PER_WORD) : 1;
  localparam int WORD_W = 2 * NUCL_PER_WORD;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_EMIT  = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [WORD_W-1:0]   word_reg, word_next;
  logic [4:0]          len_reg, len_next;

  logic                row_accept;
  logic                word_accept;
  logic                word_full;
  logic [2:0]          lt_cum;
  logic [1:0]          code;

  assign row_ready   = (state_reg == ST_ACCUM);
  assign word_valid  = (state_reg == ST_EMIT);
  assign row_accept  = row_valid && row_ready;
  assign word_accept = word_valid && word_ready;
  assign word_full   = (idx_reg == IDX_W'(NUCL_PER_WORD - 1));

  // Strict less-than per entry; priority below makes ties resolve to lowest k.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cmp
      assign lt_cum[gi] = rand_val < row_data[PROB_W*gi +: PROB_W];
    end
  endgenerate

  always_comb begin
    code = 2'd3;
    if (lt_cum[2]) code = 2'd2;
    if (lt_cum[1]) code = 2'd1;
    if (lt_cum[0]) code = 2'd0;
  end

  // Each 2-bit slot either clears on word hand-off, captures the new code, or holds.
  generate
    for (genvar gi = 0; gi < NUCL_PER_WORD; gi++) begin : g_slot
      assign word_next[2*gi +: 2] =
          word_accept                                 ? 2'b00 :
          (row_accept && (idx_reg == IDX_W'(gi)))     ? code  :
                                                        word_reg[2*gi +: 2];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    len_next   = len_reg;
    case (state_reg)
      ST_ACCUM: begin
        if (row_accept) begin
          if (word_full || row_last) begin
            state_next = ST_EMIT;
            len_next   = 5'(idx_reg) + 5'd1;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      ST_EMIT: begin
        if (word_accept) begin
          state_next = ST_ACCUM;
          idx_next   = '0;
        end
      end
      default: state_next = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_ACCUM;
      idx_reg   <= '0;
      word_reg  <= '0;
      len_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      word_reg  <= word_next;
      len_reg   <= len_next;
    end
  end

  assign word_data = word_reg;
  assign word_len  = len_reg;

`ifdef PROB_ROW_CHECK_EN
  logic prob_err_reg;
  logic row_bad;

  // A well-formed cumulative row is non-decreasing across A,C,G,T.
  assign row_bad = (row_data[0*PROB_W +: PROB_W] > row_data[1*PROB_W +: PROB_W]) ||
                   (row_data[1*PROB_W +: PROB_W] > row_data[2*PROB_W +: PROB_W]) ||
                   (row_data[2*PROB_W +: PROB_W] > row_data[3*PROB_W +: PROB_W]);

  always_ff @(posedge clk) begin
    if (reset) begin
      prob_err_reg <= 1'b0;
    end else if (row_accept && row_bad) begin
      prob_err_reg <= 1'b1;
    end
  end

  assign prob_err = prob_err_reg;
`else
  assign prob_err = 1'b0;
`endif

endmodule
